// File: rtl/uart_rx_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - FSM state encoding for uart_rx (IDLE, START, DATA, PARITY, STOP)
//   - OVERSAMPLE: ticks per bit period
//   - MID_SAMPLE: tick index at the middle of the start bit
//   - clog2: ceiling log2, shared with the baud rate generator
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Ceiling log2. clog2(1) = 0, clog2(16) = 4, clog2(24) = 5.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync_ff.sv
// sync_ff: NB_SYNC-deep bit synchronizer for an asynchronous input.
// The flops reset to 1, which matches an idle-high serial line.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high reset (stages forced to 1)
//   d     - asynchronous input bit
//   q     - synchronized output, NB_SYNC cycles behind d
module sync_ff #(
  parameter int NB_SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [NB_SYNC-1:0] stages;

  // Shift the async bit through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[NB_SYNC-2:0], d};
    end
  end

  assign q = stages[NB_SYNC-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver driven by a 16x oversampling tick.
// Frame: start bit, NB_DATA data bits LSB first, optional even parity bit
// (build with macro UART_RX_PARITY_EN), then the stop interval of SB_TICK ticks.
// Ports:
//   i_clk          - system clock
//   i_reset        - synchronous, active-high reset
//   i_s_tick       - one-cycle oversampling tick, 16 per bit period
//   i_rx           - asynchronous serial line, idle high
//   o_dout         - last received word, held until the next frame completes
//   o_rx_done_tick - one-cycle strobe when o_dout and the error flags update
//   o_frame_err    - stop bit sampled low in the last frame
//   o_parity_err   - parity mismatch in the last frame (0 without parity)
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int NB_SYNC = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_dout,
  output logic               o_rx_done_tick,
  output logic               o_frame_err,
  output logic               o_parity_err
);

  localparam int S_W = (clog2(SB_TICK) > 4) ? clog2(SB_TICK) : 4;
  localparam int N_W = (clog2(NB_DATA) > 1) ? clog2(NB_DATA) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(MID_SAMPLE);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [S_W-1:0] S_ONE  = S_W'(1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);
  localparam logic [N_W-1:0] N_ONE  = N_W'(1);

  logic               rx_s;
  logic [2:0]         state;
  logic [S_W-1:0]     s_cnt;
  logic [N_W-1:0]     n_cnt;
  logic [NB_DATA-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
  logic               parity_bit;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic parity_mismatch(input logic [NB_DATA-1:0] d,
                                           input logic p);
    return (^d) ^ p;
  endfunction
`endif

  sync_ff #(
    .NB_SYNC (NB_SYNC)
  ) u_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .d     (i_rx),
    .q     (rx_s)
  );

  // Frame recovery FSM; outputs are registered when the stop interval ends.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      shift_reg      <= '0;
      o_dout         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit     <= 1'b0;
`endif
    end else begin
      o_rx_done_tick <= 1'b0;
`ifndef UART_RX_PARITY_EN
      o_parity_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Falling edge detection does not wait for a tick.
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                // Line went high again by mid start bit: a glitch.
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (s_cnt == S_BIT) begin
              shift_reg <= {rx_s, shift_reg[NB_DATA-1:1]};
              s_cnt     <= '0;
              if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_cnt <= n_cnt + N_ONE;
              end
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_s_tick) begin
            if (s_cnt == S_BIT) begin
              parity_bit <= rx_s;
              s_cnt      <= '0;
              state      <= STOP;
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
`endif
        STOP: begin
          if (i_s_tick) begin
            if (s_cnt == S_STOP) begin
              state          <= IDLE;
              o_dout         <= shift_reg;
              o_frame_err    <= ~rx_s;
              o_rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
              o_parity_err   <= parity_mismatch(shift_reg, parity_bit);
`endif
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          s_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// word and flags per frame; a monitor pops and compares on each done strobe.
// Tick every 4 clocks, 64 clocks per bit. Honors UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
  logic       parity_err;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_done = 0;
  int   gap = 0;
  int   phase = 0;

  uart_rx #(
    .NB_DATA (8),
    .SB_TICK (16),
    .NB_SYNC (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_s_tick       (s_tick),
    .i_rx           (rx),
    .o_dout         (dout),
    .o_rx_done_tick (done),
    .o_frame_err    (frame_err),
    .o_parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: one tick every 4 clocks, driven on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      s_tick = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done strobe against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done === 1'b1) begin
        gap = cyc - last_done;
        last_done = cyc;
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got strobe with dout 0x%0h expected none (t=%0t)", dout, $time);
        end else begin
          e = q.pop_front();
          check("dout", {24'h0, dout}, {24'h0, e.d});
          check("frame_err", {31'h0, frame_err}, {31'h0, e.fe});
          check("parity_err", {31'h0, parity_err}, {31'h0, e.pe});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  // exp_pe is the hand-computed parity verdict for the parity build.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_ok,
                            input logic exp_pe);
    exp_t e;
    e.d = d;
    e.fe = ~stop_ok;
`ifdef UART_RX_PARITY_EN
    e.pe = exp_pe;
`else
    e.pe = 1'b0;
`endif
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(p);
`endif
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      // Low through the stop sample, then high before the bogus start is checked.
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, {24'h0, dout}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    check({tag, "_parity_err"}, {31'h0, parity_err}, 32'h0);
  endtask

  initial begin
    int wait_cnt;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Clean frame 0x55 (four ones -> parity 0).
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    repeat (32) @(negedge clk);

    // Start glitch: low for 4 ticks only.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (32) @(negedge clk);

    // Framing error, then a clean frame clears the flag.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (128) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    repeat (32) @(negedge clk);

    // 0x07 has three ones: parity 0 mismatches, parity 1 matches.
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);
    repeat (32) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (32) @(negedge clk);

    // Reset during data bit 3.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("midframe_reset");
    reset = 1'b0;
    repeat (200) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    repeat (32) @(negedge clk);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 2000) begin
      @(negedge clk);
      wait_cnt++;
    end
    repeat (4) @(negedge clk);
    check("b2b_gap", gap, FRAME_BITS * CLKS_PER_BIT);
    check("scoreboard_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
